// File: rtl/wb_arbiter2.sv
// ---------------------------------------------------------------------------
// wb_arbiter2 -- two-master / one-slave Wishbone arbiter.
//
// Master 0 (instruction bus) and master 1 (data bus) share a single slave
// port. Arbitration is round-robin on ties and a grant is locked for as long
// as the owner keeps cyc asserted. Once granted, the slave port is a pure
// combinational pass-through of the owner, so no wait states are added.
//
// Ports:
//   clock, reset            bus clock, asynchronous active-high reset
//   mN_cyc_i/stb_i/we_i     master N cycle, strobe, write enable   (N = 0,1)
//   mN_adr_i/dat_i/sel_i    master N address, write data, byte selects
//   mN_dat_o/ack_o/err_o    read data, ack and error back to master N
//   s_cyc_o/stb_o/we_o      slave control
//   s_adr_o/dat_o/sel_o     slave address, write data, byte selects
//   s_dat_i/ack_i/err_i     slave read data, ack, error
//   grant                   registered one-hot owner (01 = m0, 10 = m1)
//
// Optional feature: define WB_ARBITER2_TIMEOUT_EN to add a bus watchdog.
// After TIMEOUT unanswered strobe cycles the owner receives a one-cycle
// error, the slave strobe is dropped for that cycle and the count restarts.
// ---------------------------------------------------------------------------
module wb_arbiter2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  // master 0
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  // master 1
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  // slave
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  // current owner
  output logic [1:0]            grant
);

  // State encoding is the one-hot grant itself, so grant is simply the
  // state register.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  logic [1:0]            state_q, state_d;
  logic                  last_q, last_d;     // most recent owner
  logic [DATA_WIDTH-1:0] m0_dat_q, m1_dat_q; // held read data for non-owners
  logic                  timeout_s;

  assign grant = state_q;

`ifdef WB_ARBITER2_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic [15:0] wdog_q, wdog_d;

  assign timeout_s = (state_q != IDLE) && (wdog_q == TIMEOUT_C);

  // Watchdog next-state: count unanswered strobe cycles of the current owner.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == IDLE) begin
      wdog_d = 16'd0;
    end else if (timeout_s || s_ack_i || s_err_i) begin
      wdog_d = 16'd0;
    end else if (s_cyc_o && s_stb_o) begin
      wdog_d = wdog_q + 16'd1;
    end else begin
      wdog_d = wdog_q;
    end
  end

  // Watchdog register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_q <= 16'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Arbitration: lock while the owner holds cyc; on release hand straight to
  // the other master if it is waiting, ties go to the master that was not last.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_d = OWN0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0: begin
        if (m0_cyc_i) begin
          state_d = OWN0;
        end else begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (m1_cyc_i) begin
          state_d = OWN1;
        end else begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? OWN0 : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        last_d  = last_q;
      end
    endcase
  end

  // State and last-owner registers; last resets to 1 so m0 wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Capture slave read data while owned, so a master keeps seeing its last
  // value after losing the bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m0_dat_q <= '0;
      m1_dat_q <= '0;
    end else begin
      m0_dat_q <= (state_q == OWN0) ? s_dat_i : m0_dat_q;
      m1_dat_q <= (state_q == OWN1) ? s_dat_i : m1_dat_q;
    end
  end

  // Combinational bus mux: slave port follows the owner, responses go only
  // to the owner.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_dat_o = m0_dat_q;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = m1_dat_q;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      OWN0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~timeout_s;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | timeout_s;
      end
      OWN1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~timeout_s;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | timeout_s;
      end
      default: begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter2 -- self-checking bench for wb_arbiter2.
// A behavioural owner/last model predicts every output each cycle; directed
// sequences pin the model with literal expectations, then random traffic runs.
// ---------------------------------------------------------------------------
module tb_wb_arbiter2;

  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0;
  logic [3:0]  m0_sel_i = '0;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [31:0] m1_adr_i = '0, m1_dat_i = '0;
  logic [3:0]  m1_sel_i = '0;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 1'b0, s_err_i = 1'b0;
  logic [1:0]  grant;

  int total = 0;
  int bad   = 0;

  wb_arbiter2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant(grant)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_owner = -1;   // -1 none, 0 or 1
  bit          m_last  = 1'b1;
  logic [31:0] m_dat0  = '0, m_dat1 = '0;
  int          m_cnt   = 0;

  // Who was the last owner once this edge has been taken into account.
  function automatic bit upd_last(int own, bit lst, bit r0, bit r1);
    if (own == 0 && !r0) return 1'b0;
    if (own == 1 && !r1) return 1'b1;
    return lst;
  endfunction

  // Owner after the edge: keep a locked owner, otherwise serve requesters,
  // ties go to whichever master was not last.
  function automatic int pick(int own, bit lst, bit r0, bit r1);
    if (own == 0 && r0) return 0;
    if (own == 1 && r1) return 1;
    if (r0 && r1) return lst ? 0 : 1;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic bit tmo_now();
`ifdef WB_ARBITER2_TIMEOUT_EN
    return (m_owner >= 0) && (m_cnt == TMO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int cnt_next();
`ifdef WB_ARBITER2_TIMEOUT_EN
    bit stb;
    stb = (m_owner == 0) ? (m0_cyc_i & m0_stb_i) : (m1_cyc_i & m1_stb_i);
    if (m_owner < 0) return 0;
    if (m_cnt == TMO || s_ack_i || s_err_i) return 0;
    if (stb) return m_cnt + 1;
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_owner <= -1;
      m_last  <= 1'b1;
      m_dat0  <= '0;
      m_dat1  <= '0;
      m_cnt   <= 0;
    end else begin
      if (m_owner == 0) m_dat0 <= s_dat_i;
      if (m_owner == 1) m_dat1 <= s_dat_i;
      m_owner <= pick(m_owner, upd_last(m_owner, m_last, m0_cyc_i, m1_cyc_i), m0_cyc_i, m1_cyc_i);
      m_last  <= upd_last(m_owner, m_last, m0_cyc_i, m1_cyc_i);
      m_cnt   <= cnt_next();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (!reset) begin
      chk("grant", grant, (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00);
      chk("s_cyc", s_cyc_o, (m_owner == 0) ? m0_cyc_i : (m_owner == 1) ? m1_cyc_i : 1'b0);
      chk("s_stb", s_stb_o, ((m_owner == 0) ? m0_stb_i : (m_owner == 1) ? m1_stb_i : 1'b0) & !tmo_now());
      chk("s_we", s_we_o, (m_owner == 0) ? m0_we_i : (m_owner == 1) ? m1_we_i : 1'b0);
      if (m_owner >= 0) begin
        chk("s_adr", s_adr_o, (m_owner == 0) ? m0_adr_i : m1_adr_i);
        chk("s_dat", s_dat_o, (m_owner == 0) ? m0_dat_i : m1_dat_i);
        chk("s_sel", s_sel_o, (m_owner == 0) ? m0_sel_i : m1_sel_i);
      end
      chk("m0_ack", m0_ack_o, (m_owner == 0) & s_ack_i);
      chk("m1_ack", m1_ack_o, (m_owner == 1) & s_ack_i);
      chk("m0_err", m0_err_o, (m_owner == 0) & (s_err_i | tmo_now()));
      chk("m1_err", m1_err_o, (m_owner == 1) & (s_err_i | tmo_now()));
      chk("m0_dat", m0_dat_o, (m_owner == 0) ? s_dat_i : m_dat0);
      chk("m1_dat", m1_dat_o, (m_owner == 1) ? s_dat_i : m_dat1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    @(negedge clock);
  endtask

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // reset state
    step(); step();
    look();
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc_o, 1'b0);
    chk("rst_acks", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0000);
    chk("rst_m0_dat", m0_dat_o, 32'h0);
    step(); reset = 1'b0;

    // m0 read at 0x10, slave answers 0xDEADBEEF two cycles into the grant
    step(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 32'h0000_0010; m0_sel_i = 4'hF;
    look(); chk("A_latency", grant, 2'b00);
    step(); look();
    chk("A_grant", grant, 2'b01);
    chk("A_adr", s_adr_o, 32'h0000_0010);
    step();
    step(); s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    look();
    chk("A_ack", m0_ack_o, 1'b1);
    chk("A_dat", m0_dat_o, 32'hDEAD_BEEF);
    chk("A_m1_ack", m1_ack_o, 1'b0);
    step(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    look();
    chk("A_release_cyc", s_cyc_o, 1'b0);
    chk("A_release_grant", grant, 2'b01);
    step(); look();
    chk("A_idle", grant, 2'b00);
    chk("A_dat_hold", m0_dat_o, 32'hDEAD_BEEF);
    s_dat_i = 32'h0;

    // simultaneous requests after reset, handoff, alternation
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    step(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    look(); chk("B_latency", grant, 2'b00);
    step(); look(); chk("B_first_m0", grant, 2'b01);
    step(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    look(); chk("B_lock", grant, 2'b01);
    step(); look(); chk("B_handoff", grant, 2'b10);
    step(); m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step(); look(); chk("B_idle", grant, 2'b00);
    step(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    step(); look(); chk("B_alternate", grant, 2'b01);
    step(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step(); step();

    // m1 burst of three writes while m0 waits
    step(); m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'hF000_0000; m1_dat_i = 32'h1111_1111;
    step(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    look(); chk("C_grant", grant, 2'b10);
    for (int k = 0; k < 3; k++) begin
      step(); m1_adr_i = 32'hF000_0000 + 32'(4 * k); s_ack_i = 1'b1;
      look();
      chk("C_lock", grant, 2'b10);
      chk("C_m0_ack", m0_ack_o, 1'b0);
      chk("C_m1_ack", m1_ack_o, 1'b1);
      chk("C_adr", s_adr_o, 32'hF000_0000 + 32'(4 * k));
    end
    step(); m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; s_ack_i = 1'b0;
    look(); chk("C_hold", grant, 2'b10);
    step(); look(); chk("C_to_m0", grant, 2'b01);
    step(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step(); step();

    // asynchronous reset in the middle of an m1 transfer
    step(); m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    step(); look(); chk("D_grant", grant, 2'b10);
    step(); s_ack_i = 1'b1; reset = 1'b1;
    #1;
    chk("D_s_cyc", s_cyc_o, 1'b0);
    chk("D_s_stb", s_stb_o, 1'b0);
    chk("D_grant0", grant, 2'b00);
    chk("D_no_ack", m1_ack_o, 1'b0);
    step(); reset = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    step(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    step(); look(); chk("D_m0_wins", grant, 2'b01);
    step(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step(); step(); step();

    // slave never answers
    step(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      look();
      chk("E_grant", grant, 2'b01);
`ifdef WB_ARBITER2_TIMEOUT_EN
      chk("E_err", m0_err_o, (k == TMO) ? 1'b1 : 1'b0);
      chk("E_stb", s_stb_o, (k == TMO) ? 1'b0 : 1'b1);
`else
      chk("E_err", m0_err_o, 1'b0);
      chk("E_stb", s_stb_o, 1'b1);
`endif
      step();
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step(); step();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step();
      reset = ($urandom_range(499) == 0);
      if (m0_cyc_i) m0_cyc_i = ($urandom_range(3) != 0);
      else          m0_cyc_i = ($urandom_range(2) == 0);
      if (m1_cyc_i) m1_cyc_i = ($urandom_range(3) != 0);
      else          m1_cyc_i = ($urandom_range(2) == 0);
      m0_stb_i = $urandom_range(1);
      m1_stb_i = $urandom_range(1);
      m0_we_i  = $urandom_range(1);
      m1_we_i  = $urandom_range(1);
      m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom_range(15));
      m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom_range(15));
      s_dat_i  = $urandom;
      s_ack_i  = ($urandom_range(2) == 0);
      s_err_i  = ($urandom_range(7) == 0);
    end
    step(); reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
